// File: rtl/pdua_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdua_int_pkg
// Description : Shared FSM encoding, defaults and vector helper for the
//               PDUA interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pdua_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam int         c_n_irq_default    = 4;
  localparam logic [7:0] c_vec_base_default = 8'hF0;

  // Handler entries are two bytes apart; the sum wraps within 8 bits.
  function automatic logic [7:0] vec_addr(input logic [7:0] base, input int unsigned idx);
    return base + 8'(idx << 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdua_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pdua_sync_edge
// Description : 2-flop synchronizer plus rising-edge detector for one line.
// Revision    : 1.0 - initial release
// ============================================================================
module pdua_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_prev;
  logic [2:0] r_warm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_warm <= 3'b000;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_warm <= {r_warm[1:0], 1'b1};
    end
  end

  // Edges are ignored until the pipeline holds real samples, so a line
  // already high when reset releases is not mistaken for a new request.
  assign rise = r_s2 & ~r_prev & r_warm[2];

endmodule
`default_nettype wire

// File: rtl/pdua_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdua_int_ctrl
// Description : Masked, fixed-priority, non-nesting interrupt controller
//               for the PDUA control unit (INT / inta / eoi handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module pdua_int_ctrl
  import pdua_int_pkg::*;
#(
  parameter int         N_IRQ    = c_n_irq_default,
  parameter logic [7:0] VEC_BASE = c_vec_base_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             inta,
  input  logic             eoi,
  output logic             INT,
  output logic [7:0]       vector,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  localparam int c_sw = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_sw-1:0]  r_sel;
  logic [c_sw-1:0]  w_win;
  logic             w_any;
  logic             w_take;
  logic             w_ack;
  logic             w_done;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_req;
  logic [N_IRQ-1:0] w_sel_oh;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_in_service;
  logic [N_IRQ-1:0] r_mask;
  logic             r_int;
  logic [7:0]       r_vector;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    pdua_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (irq[g]),
      .rise (w_rise[g])
    );
  end

  assign w_req    = r_pending & r_mask;
  assign w_sel_oh = {{(N_IRQ-1){1'b0}}, 1'b1} << r_sel;

  // Scan from the top so the lowest requesting index is the last one kept.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_win = c_sw'(i);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ack       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) begin
        w_state_nxt = ST_REQ;
        w_take      = 1'b1;
      end
      ST_REQ: if (inta) begin
        w_state_nxt = ST_SERVICE;
        w_ack       = 1'b1;
      end
      ST_SERVICE: if (eoi) begin
        w_state_nxt = ST_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel        <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_mask       <= '0;
      r_int        <= 1'b0;
      r_vector     <= VEC_BASE;
    end else begin
      if (mask_we) r_mask <= mask_wdata;
      // A fresh edge on the acknowledged line survives its own clear.
      r_pending <= (w_ack ? (r_pending & ~w_sel_oh) : r_pending) | w_rise;
      if (w_take) begin
        r_sel    <= w_win;
        r_int    <= 1'b1;
        r_vector <= vec_addr(VEC_BASE, 32'(w_win));
      end
      if (w_ack) begin
        r_in_service <= w_sel_oh;
        r_int        <= 1'b0;
      end
      if (w_done) r_in_service <= '0;
    end
  end

  assign INT        = r_int;
  assign vector     = r_vector;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_pdua_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdua_int_ctrl
// Description : Directed plus randomized bench for pdua_int_ctrl against a
//               sample-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdua_int_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq = 4'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       INT;
  logic [7:0] vector;
  logic [3:0] in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_pend, m_mask, m_insvc;
  logic       m_int;
  logic [7:0] m_vec;
  int         m_phase, m_sel, n_edges;
  logic [3:0] h1, h2, h3;

  always #5 clk = ~clk;

  pdua_int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .inta       (inta),
    .eoi        (eoi),
    .INT        (INT),
    .vector     (vector),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_insvc = 0; m_int = 0; m_vec = 8'hF0;
    m_phase = P_IDLE; m_sel = 0; n_edges = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  // h1/h2/h3 are irq as sampled 1/2/3 clock edges ago.
  task automatic model_edge();
    logic [3:0] newset;
    if (!rst) begin
      model_reset();
      return;
    end
    n_edges++;
    newset = (n_edges >= 4) ? (h2 & ~h3) : 4'b0;
    h3 = h2; h2 = h1; h1 = irq;
    case (m_phase)
      P_IDLE: if ((m_pend & m_mask) != 0) begin
        m_sel = lowest(m_pend & m_mask);
        m_phase = P_REQ; m_int = 1'b1;
        m_vec = 8'hF0 + 8'(2 * m_sel);
      end
      P_REQ: if (inta) begin
        m_pend[m_sel] = 1'b0;
        m_insvc = 4'b0001 << m_sel;
        m_int = 1'b0; m_phase = P_SVC;
      end
      P_SVC: if (eoi) begin
        m_insvc = 0; m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    m_pend = m_pend | newset;
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic check_all();
    chk("model_INT", INT, m_int);
    chk("model_vector", vector, m_vec);
    chk("model_pending", pending, m_pend);
    chk("model_in_service", in_service, m_insvc);
    chk("model_mask", mask, m_mask);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_INT", INT, 0);
    chk("rst_vector", vector, 8'hF0);
    chk("rst_mask", mask, 0);
    chk("rst_pending", pending, 0);
    chk("rst_in_service", in_service, 0);
    repeat (4) tick();

    inta = 1; eoi = 1; tick(); inta = 0; eoi = 0; tick();
    chk("stray_INT", INT, 0);
    chk("stray_in_service", in_service, 0);

    mask_we = 1; mask_wdata = 4'hF; tick(); mask_we = 0;
    chk("mask_write", mask, 4'hF);
    irq = 4'b0100; tick(); irq = 0; tick();
    chk("single_pend_early", pending, 4'b0000);
    tick();
    chk("single_pend", pending, 4'b0100);
    chk("single_int_low", INT, 0);
    tick();
    chk("single_INT", INT, 1);
    chk("single_vector", vector, 8'hF4);
    inta = 1; tick(); inta = 0;
    chk("single_ack_pend", pending, 4'b0000);
    chk("single_ack_isvc", in_service, 4'b0100);
    chk("single_ack_INT", INT, 0);
    eoi = 1; tick(); eoi = 0;
    chk("single_eoi_isvc", in_service, 4'b0000);

    irq = 4'b1010; tick(); irq = 0; repeat (3) tick();
    chk("prio_vector1", vector, 8'hF2);
    chk("prio_INT1", INT, 1);
    inta = 1; tick(); inta = 0; eoi = 1; tick(); eoi = 0;
    tick();
    chk("prio_vector2", vector, 8'hF6);
    chk("prio_INT2", INT, 1);
    inta = 1; tick(); inta = 0; eoi = 1; tick(); eoi = 0; tick();

    irq = 4'b0010; tick(); irq = 0; repeat (3) tick();
    chk("bnd_vector", vector, 8'hF2);
    irq = 4'b0010; tick(); tick();
    inta = 1; tick(); inta = 0; irq = 0;
    chk("bnd_pend_kept", pending, 4'b0010);
    chk("bnd_isvc", in_service, 4'b0010);
    eoi = 1; tick(); eoi = 0; tick();
    chk("bnd_reassert", INT, 1);
    chk("bnd_vector2", vector, 8'hF2);
    inta = 1; tick(); inta = 0; eoi = 1; tick(); eoi = 0;

    mask_we = 1; mask_wdata = 4'b0000; tick(); mask_we = 0;
    irq = 4'b0001; tick(); irq = 0; repeat (4) tick();
    chk("masked_pend", pending, 4'b0001);
    chk("masked_INT", INT, 0);
    mask_we = 1; mask_wdata = 4'b0001; tick(); mask_we = 0; tick();
    chk("unmask_INT", INT, 1);
    chk("unmask_vector", vector, 8'hF0);
    inta = 1; tick(); inta = 0;
    chk("svc_isvc", in_service, 4'b0001);

    irq = 4'b1000;
    #2; rst = 1'b0; #1;
    model_reset();
    chk("arst_INT", INT, 0);
    chk("arst_vector", vector, 8'hF0);
    chk("arst_pending", pending, 0);
    chk("arst_in_service", in_service, 0);
    chk("arst_mask", mask, 0);
    tick(); tick(); rst = 1'b1;
    repeat (6) tick();
    chk("held_high_no_edge", pending, 0);
    irq = 0;

    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) irq[b] = ~irq[b];
      inta       = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 2) == 0);
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdua_int_ctrl.md
PDUA_INT_CTRL -- requirements
Module: pdua_int_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt request lines.
REQ-002 Parameter VEC_BASE, default 8'hF0: vector address for line 0.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 irq  input  N_IRQ  asynchronous peripheral request lines, rising-edge sensitive.
REQ-006 mask_we  input  1  mask register write strobe.
REQ-007 mask_wdata  input  N_IRQ  new mask value; bit=1 enables that line.
REQ-008 inta  input  1  acknowledge pulse from the PDUA control unit.
REQ-009 eoi  input  1  end-of-interrupt pulse from the control unit.
REQ-010 INT  output  1  interrupt request to the control unit's INT input.
REQ-011 vector  output  8  handler address of the winning line.
REQ-012 in_service  output  N_IRQ  one-hot, marks the line currently being serviced.
REQ-013 pending  output  N_IRQ  latched, not yet acknowledged requests.
REQ-014 mask  output  N_IRQ  current mask register.

Function
REQ-015 Each irq bit SHALL pass a 2-flop synchronizer followed by a rising-edge detector.
REQ-016 A detected edge SHALL set pending[i] on the following edge: 3 clk edges from irq rising to pending set.
REQ-017 Pending bits SHALL be set regardless of mask; masked bits stay pending until unmasked and serviced.
REQ-018 mask_we=1 SHALL load mask_wdata on the same edge, in any FSM state.
REQ-019 Priority: lowest index among (pending & mask) wins.
REQ-020 FSM states: IDLE, REQ, SERVICE.
REQ-021 IDLE -> REQ when (pending & mask) != 0; winner index latched into sel on that edge.
REQ-022 REQ: INT=1 and vector = VEC_BASE + 2*sel (8-bit, wraps modulo 256). Both are registered and stable until inta.
REQ-023 REQ -> SERVICE on inta=1: pending[sel] cleared and in_service[sel] set on that edge; INT=0 from the next cycle.
REQ-024 SERVICE -> IDLE on eoi=1: in_service cleared. No nesting; new requests wait for IDLE.
REQ-025 Mask change during REQ SHALL NOT retract the request or change sel.
REQ-026 inta outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-027 If an edge on line sel coincides with its inta clear, set wins: pending[sel] stays 1.
REQ-028 In IDLE, vector holds its last value and INT=0.

Reset
REQ-029 rst=0 SHALL immediately force:
- state=IDLE, INT=0, vector=VEC_BASE
- pending=0, in_service=0, mask=0, sel=0
- synchronizer and edge-detector flops to 0
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL discard the request; there is no recovery state.
REQ-031 A line held high through reset release SHALL NOT produce an edge.

Structure
REQ-032 A shared package pdua_int_pkg SHALL hold the FSM state encoding, the N_IRQ default and the VEC_BASE default.
REQ-033 One sub-module, pdua_sync_edge (synchronizer plus edge detector, 1 bit), SHALL be instantiated per line.

Verification
REQ-034 Reset check: rst=0 for 2 cycles, then 1 with irq=4'b0000 -> INT=0, vector=8'hF0, mask/pending/in_service=0.
REQ-035 Single request: mask=4'b1111, pulse irq[2] -> pending=4'b0100 after 3 edges, INT=1 the next cycle, vector=8'hF4; inta -> pending=0, in_service=4'b0100; eoi -> in_service=0.
REQ-036 Priority: irq[3] and irq[1] rise together -> vector=8'hF2 first; after inta and eoi, second request vector=8'hF6.
REQ-037 Masking: mask=4'b0000, pulse irq[0] -> pending=4'b0001, INT stays 0; write mask=4'b0001 -> INT=1, vector=8'hF0.
REQ-038 Boundary: second irq[1] edge on the inta clear edge -> pending[1] stays 1; INT reasserts after eoi. Stray inta/eoi in IDLE -> no state change.
REQ-039 Reset in SERVICE: rst=0 while in_service=4'b0001 -> all outputs return to reset values asynchronously.
